// File: rtl/controla_fluxo_param.sv
// Parking-gate flow controller with occupancy count, password retry lockout and exit accounting.
// Optional wait timeouts in ESPERANDO_SENHA/ESTACIONANDO are enabled by defining ESPERA_TIMEOUT_EN.
module controla_fluxo_param #(
  parameter int CAPACITY  = 16,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 1000,
  parameter int LOCKOUT   = 500,
  localparam int OW = $clog2(CAPACITY + 1)
) (
  input  logic          Clock,
  input  logic          reset,
  input  logic          SE,
  input  logic          SI,
  input  logic          SaidaCarro,
  input  logic          SenhaOk,
  input  logic          SenhaInvalida,
  output logic          Liberado,
  output logic          Pare,
  output logic          Bloqueado,
  output logic          SenhaErro,
  output logic          Full,
  output logic [OW-1:0] Ocupacao,
  output logic [2:0]    state
);

  localparam int TMAX = (TIMEOUT > LOCKOUT) ? TIMEOUT : LOCKOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    INICIAL         = 3'd0,
    ESPERANDO_SENHA = 3'd1,
    ESTACIONANDO    = 3'd2,
    PARE            = 3'd3,
    BLOQUEADO       = 3'd4,
    TRAVADO         = 3'd5
  } state_t;

  state_t        cur, nxt;
  logic [TW-1:0] timer;
  logic [RW-1:0] tries, tries_nxt, tries_inc;
  logic          passou, passou_nxt;
  logic          erro_nxt;
  logic          inc;
  logic          full;
  logic          timeout;
  logic          lock_done;

  assign full      = (Ocupacao == OW'(CAPACITY));
  assign tries_inc = tries + RW'(1);
  assign lock_done = (timer == TW'(LOCKOUT - 1));

`ifdef ESPERA_TIMEOUT_EN
  assign timeout = (timer == TW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    nxt        = cur;
    tries_nxt  = tries;
    passou_nxt = passou;
    erro_nxt   = 1'b0;
    inc        = 1'b0;
    case (cur)
      INICIAL: begin
        if (full)    nxt = BLOQUEADO;
        else if (SE) nxt = ESPERANDO_SENHA;
      end
      ESPERANDO_SENHA: begin
        // An invalid pulse wins over a simultaneous valid one.
        if (full) begin
          nxt = BLOQUEADO;
        end else if (SenhaInvalida) begin
          erro_nxt  = 1'b1;
          tries_nxt = tries_inc;
          if (tries_inc == RW'(MAX_TRIES)) nxt = TRAVADO;
        end else if (SenhaOk) begin
          nxt        = ESTACIONANDO;
          tries_nxt  = '0;
          passou_nxt = 1'b0;
        end else if (timeout) begin
          nxt = INICIAL;
        end
      end
      ESTACIONANDO: begin
        if (SI) passou_nxt = 1'b1;
        if (SE && SI) begin
          nxt = PARE;
        end else if (!SE && !SI && passou) begin
          nxt = INICIAL;
          inc = 1'b1;
        end else if (timeout) begin
          nxt = INICIAL;
        end
      end
      PARE: begin
        if (!(SE && SI)) nxt = ESTACIONANDO;
      end
      BLOQUEADO: begin
        if (!full) nxt = INICIAL;
      end
      TRAVADO: begin
        if (lock_done) nxt = INICIAL;
      end
      default: nxt = INICIAL;
    endcase
    // Retry count survives only the password-wait timeout loop.
    if (nxt == INICIAL && cur != ESPERANDO_SENHA) tries_nxt = '0;
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      cur       <= INICIAL;
      timer     <= '0;
      tries     <= '0;
      passou    <= 1'b0;
      SenhaErro <= 1'b0;
      Ocupacao  <= '0;
    end else begin
      cur       <= nxt;
      tries     <= tries_nxt;
      passou    <= passou_nxt;
      SenhaErro <= erro_nxt;
      if (nxt != cur)      timer <= '0;
      else if (timer != '1) timer <= timer + TW'(1);
      case ({inc, SaidaCarro})
        2'b10:   if (!full) Ocupacao <= Ocupacao + OW'(1);
        2'b01:   if (Ocupacao != '0) Ocupacao <= Ocupacao - OW'(1);
        default: Ocupacao <= Ocupacao;
      endcase
    end
  end

  assign state     = cur;
  assign Full      = full;
  assign Liberado  = (cur == ESTACIONANDO);
  assign Pare      = (cur == PARE);
  assign Bloqueado = (cur == BLOQUEADO) || (cur == TRAVADO);

endmodule

// File: doc/controla_fluxo_param.md
# controla_fluxo_param

Parametrised parking-gate flow controller, the successor to the fixed single-gate controller. It adds four capabilities: an internal occupancy counter with configurable capacity, a bounded password-retry count with a timed lockout, optional wait timeouts, and exit-sensor accounting. It sits between the gate sensors and password keypad logic on one side and the barrier, stop-light and display drivers on the other.

## Interface
Parameters:
- CAPACITY, 16: number of parking spaces; must be ≥1.
- MAX_TRIES, 3: consecutive invalid passwords that trigger lockout; must be ≥1.
- TIMEOUT, 1000: cycles allowed in ESPERANDO_SENHA or ESTACIONANDO before abandoning; must be ≥1.
- LOCKOUT, 500: cycles spent in TRAVADO; must be ≥1.

Ports (OW = $clog2(CAPACITY+1)):
- Clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- SE  in  1  entry sensor; car present at the gate.
- SI  in  1  inner sensor; car past the barrier.
- SaidaCarro  in  1  one-cycle pulse per car leaving.
- SenhaOk  in  1  one-cycle pulse: valid password entered.
- SenhaInvalida  in  1  one-cycle pulse: invalid password entered.
- Liberado  out  1  barrier open.
- Pare  out  1  stop light.
- Bloqueado  out  1  entry refused (lot full or lockout).
- SenhaErro  out  1  one-cycle pulse on each invalid attempt.
- Full  out  1  Ocupacao == CAPACITY.
- Ocupacao  out  OW  cars currently inside.
- state  out  3  current FSM state.

## Operation
- State encoding: INICIAL=0, ESPERANDO_SENHA=1, ESTACIONANDO=2, PARE=3, BLOQUEADO=4, TRAVADO=5. Unused codes go to INICIAL on the next edge.
- INICIAL:
  - Full → BLOQUEADO.
  - Otherwise SE → ESPERANDO_SENHA.
- ESPERANDO_SENHA, priority order:
  - Full → BLOQUEADO.
  - SenhaInvalida: tries++ and pulse SenhaErro. If the new tries == MAX_TRIES → TRAVADO.
  - SenhaOk → ESTACIONANDO and tries cleared.
  - Timeout → INICIAL.
  - SenhaOk and SenhaInvalida asserted together are treated as invalid only.
- ESTACIONANDO:
  - SE&SI → PARE.
  - SI sets the internal flag passou.
  - ~SE&~SI with passou=1 → INICIAL and Ocupacao++, saturating at CAPACITY.
  - Timeout → INICIAL with no increment.
- PARE: stay while SE&SI; otherwise → ESTACIONANDO. The passou flag is kept.
- BLOQUEADO: stay while Full; ~Full → INICIAL.
- TRAVADO: stay for exactly LOCKOUT cycles, then → INICIAL with tries cleared. Full and SE are ignored.
- tries is cleared on entering INICIAL from any state other than ESPERANDO_SENHA. It persists across INICIAL↔ESPERANDO_SENHA timeouts only when retrying.
- passou is cleared on entering ESTACIONANDO from ESPERANDO_SENHA.
- Moore outputs, decoded from state:
  - ESTACIONANDO: Liberado=1.
  - PARE: Pare=1.
  - BLOQUEADO and TRAVADO: Bloqueado=1.
  - All other states: all three are 0.
- SenhaErro is a registered pulse, high in the cycle after the SenhaInvalida edge.
- Ocupacao changes per edge:
  - SaidaCarro decrements, saturating at 0.
  - Increment and decrement in the same edge leave Ocupacao unchanged.
  - SaidaCarro is honoured in every state.
- Full is combinational from Ocupacao.

## Timing
- Reset values: state=INICIAL, Ocupacao=0, tries=0, timer=0, passou=0. Liberado, Pare, Bloqueado, SenhaErro and Full are all 0.
- All transitions take effect on the rising Clock edge. Outputs reflect the new state in that same cycle.
- Shared timer:
  - Cleared on every state change.
  - Increments while the state is unchanged.
  - Timeout fires when timer == TIMEOUT-1, so the state is left after exactly TIMEOUT cycles.
  - Lockout fires when timer == LOCKOUT-1.
  - Timer width is $clog2(max(TIMEOUT,LOCKOUT)+1).
- Asserting reset mid-operation immediately forces all reset values, including Ocupacao.
- A SaidaCarro that clears Full is seen by BLOQUEADO on the next edge.

## Configuration
- ESPERA_TIMEOUT_EN defined: the TIMEOUT exits from ESPERANDO_SENHA and ESTACIONANDO are active.
- ESPERA_TIMEOUT_EN undefined: both states wait indefinitely. The timer still runs for TRAVADO, and the TIMEOUT parameter is ignored.

## Test plan
- CAPACITY=2. Two full entries (SE, SenhaOk, SI, then release both sensors) → Ocupacao=2, Full=1. The next SE leads to BLOQUEADO, Bloqueado=1. A SaidaCarro pulse → Ocupacao=1, then INICIAL on the following edge.
- MAX_TRIES=3. Three SenhaInvalida pulses in ESPERANDO_SENHA → three SenhaErro pulses, then TRAVADO, Bloqueado=1. TRAVADO lasts exactly LOCKOUT=500 cycles before INICIAL; SE is ignored meanwhile.
- In ESTACIONANDO, assert SE=SI=1 → state=PARE, Pare=1, Liberado=0. Drop SE → ESTACIONANDO, Liberado=1. Drop SI → INICIAL, Ocupacao +1.
- With ESPERA_TIMEOUT_EN and TIMEOUT=10: give SenhaOk but never assert SI → INICIAL after exactly 10 cycles in ESTACIONANDO, Ocupacao unchanged. Without the macro → still ESTACIONANDO after 10,000 cycles.
- Ocupacao=1: the increment edge coincides with a SaidaCarro pulse → Ocupacao stays 1. At Ocupacao=0, SaidaCarro → remains 0.
- Assert reset asynchronously in PARE with Ocupacao=5 → state=0, Ocupacao=0 and all outputs 0 before the next Clock edge.
